// File: rtl/rover_drive_ctrl_pkg.sv
// Shared types and constants for the rover drive controller: FSM states,
// command mode encodings and H-bridge IN[4:1] drive patterns.
package rover_drive_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_BRAKE   = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [1:0] MODE_STOP  = 2'd0;
    localparam logic [1:0] MODE_FWD   = 2'd1;
    localparam logic [1:0] MODE_PIV_L = 2'd2;
    localparam logic [1:0] MODE_PIV_R = 2'd3;

    localparam logic [3:0] IN_OFF   = 4'b0000;
    localparam logic [3:0] IN_FWD   = 4'b1010;
    localparam logic [3:0] IN_PIV_L = 4'b0110;
    localparam logic [3:0] IN_PIV_R = 4'b1001;
    localparam logic [3:0] IN_BRAKE = 4'b1111;

    function automatic logic [3:0] mode_in(input logic [1:0] mode);
        logic [3:0] pat;
        case (mode)
            MODE_FWD:   pat = IN_FWD;
            MODE_PIV_L: pat = IN_PIV_L;
            MODE_PIV_R: pat = IN_PIV_R;
            default:    pat = IN_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/rover_drive_ctrl_quad_decoder.sv
// x4 quadrature decoder: synchronises both encoder phases and emits a
// one-cycle pulse per legal single-phase transition.
module quad_decoder (
    input  logic clk,
    input  logic rst,
    input  logic i_enc_a,
    input  logic i_enc_b,
    output logic o_edge
);

    logic [1:0] r_a_sync;
    logic [1:0] r_b_sync;
    logic [1:0] r_prev;
    logic       r_edge;
    logic [1:0] w_cur;

    assign w_cur  = {r_a_sync[1], r_b_sync[1]};
    assign o_edge = r_edge;

    // Exactly one phase changing is a legal step; both changing is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sync <= 2'b00;
            r_b_sync <= 2'b00;
            r_prev   <= 2'b00;
            r_edge   <= 1'b0;
        end else begin
            r_a_sync <= {r_a_sync[0], i_enc_a};
            r_b_sync <= {r_b_sync[0], i_enc_b};
            r_prev   <= w_cur;
            r_edge   <= ^(w_cur ^ r_prev);
        end
    end

endmodule

// File: rtl/rover_drive_ctrl.sv
// Rover drive controller: accepts move commands, drives the H-bridge with PWM
// until the encoder distance is covered, brakes, and locks out on overcurrent.
module rover_drive_ctrl
    import rover_drive_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int PWM_W     = 8,
    parameter int BRAKE_CYC = 1000,
    parameter int OC_HOLD   = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_mode,
    input  logic [CNT_W-1:0] i_cmd_counts,
    input  logic [PWM_W-1:0] i_cmd_duty,
    input  logic             i_enc_a,
    input  logic             i_enc_b,
    input  logic             i_overide,
    output logic [3:0]       o_in,
    output logic             o_en_a,
    output logic             o_en_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fault
);

    localparam int HOLD_MAX = (BRAKE_CYC > OC_HOLD) ? BRAKE_CYC : OC_HOLD;
    localparam int TMR_W    = $clog2(HOLD_MAX + 1);
    localparam logic [TMR_W-1:0] BRAKE_LAST = TMR_W'(BRAKE_CYC - 1);
    localparam logic [TMR_W-1:0] OC_LAST    = TMR_W'(OC_HOLD - 1);

    state_t           r_state;
    logic             r_alive;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_counts;
    logic [CNT_W-1:0] r_edges;
    logic [PWM_W-1:0] r_duty;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [TMR_W-1:0] r_timer;
    logic [1:0]       r_ov_sync;
    logic [3:0]       r_in;
    logic             r_en;
    logic             r_done;
    logic             r_fault;

    logic w_edge;
    logic w_ov;
    logic w_pwm;
    logic w_xfer;

    quad_decoder u_quad (
        .clk     (clk),
        .rst     (rst),
        .i_enc_a (i_enc_a),
        .i_enc_b (i_enc_b),
        .o_edge  (w_edge)
    );

    assign w_ov        = r_ov_sync[1];
    assign w_pwm       = (r_pwm_cnt < r_duty);
    assign o_cmd_ready = r_alive && (r_state == ST_IDLE) && i_enable && !w_ov;
    assign w_xfer      = i_cmd_valid && o_cmd_ready;

    assign o_in    = r_in;
    assign o_en_a  = r_en;
    assign o_en_b  = r_en;
    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = r_done;
    assign o_fault = r_fault;

    // Overcurrent synchroniser and free-running PWM counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ov_sync <= 2'b00;
            r_pwm_cnt <= '0;
        end else begin
            r_ov_sync <= {r_ov_sync[0], i_overide};
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end
    end

    // Travelled-distance counter; saturates so overrun edges cannot wrap it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edges <= '0;
        end else if (w_xfer) begin
            r_edges <= '0;
        end else if (w_edge && (r_edges != {CNT_W{1'b1}})) begin
            r_edges <= r_edges + CNT_W'(1);
        end else begin
            r_edges <= r_edges;
        end
    end

    // Drive FSM; enable loss outranks overcurrent, which outranks distance reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_alive  <= 1'b0;
            r_mode   <= MODE_STOP;
            r_counts <= '0;
            r_duty   <= '0;
            r_timer  <= '0;
            r_in     <= IN_OFF;
            r_en     <= 1'b0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_done  <= 1'b0;
            if (!i_enable) begin
                r_state <= ST_IDLE;
                r_in    <= IN_OFF;
                r_en    <= 1'b0;
                r_timer <= '0;
            end else if ((r_state != ST_IDLE) && w_ov) begin
                r_state <= ST_LOCKOUT;
                r_fault <= 1'b1;
                r_in    <= IN_OFF;
                r_en    <= 1'b0;
                r_timer <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_in    <= IN_OFF;
                        r_en    <= 1'b0;
                        r_timer <= '0;
                        if (w_xfer) begin
                            r_mode   <= i_cmd_mode;
                            r_counts <= i_cmd_counts;
                            r_duty   <= i_cmd_duty;
                            r_fault  <= 1'b0;
                            if ((i_cmd_mode == MODE_STOP) || (i_cmd_counts == '0)) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                                r_in    <= mode_in(i_cmd_mode);
                                r_en    <= (r_pwm_cnt < i_cmd_duty);
                            end
                        end else if (w_ov) begin
                            r_fault <= 1'b1;
                        end else begin
                            r_fault <= r_fault;
                        end
                    end
                    ST_RUN: begin
                        if (r_edges >= r_counts) begin
                            r_state <= ST_BRAKE;
                            r_in    <= IN_BRAKE;
                            r_en    <= 1'b1;
                            r_timer <= '0;
                        end else begin
                            r_in <= mode_in(r_mode);
                            r_en <= w_pwm;
                        end
                    end
                    ST_BRAKE: begin
                        if (r_timer == BRAKE_LAST) begin
                            r_state <= ST_IDLE;
                            r_in    <= IN_OFF;
                            r_en    <= 1'b0;
                            r_done  <= 1'b1;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    ST_LOCKOUT: begin
                        if (r_timer == OC_LAST) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_in    <= IN_OFF;
                        r_en    <= 1'b0;
                        r_timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/rover_drive_ctrl.md
ROVER_DRIVE_CTRL -- requirements
Module: rover_drive_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, encoder-count width.
REQ-002 SHALL have parameter PWM_W, default 8, PWM counter/duty width.
REQ-003 SHALL have parameter BRAKE_CYC, default 1000, brake duration in clk cycles.
REQ-004 SHALL have parameter OC_HOLD, default 1000000, overcurrent lockout in clk cycles.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (system clock); rst input 1 (async active-high reset).
REQ-006 enable  input  1  master drive enable; low aborts any command.
REQ-007 cmd_valid  input  1  command offer.
REQ-008 cmd_ready  output  1  high only in IDLE; transfer when cmd_valid && cmd_ready.
REQ-009 cmd_mode  input  2  0 stop, 1 forward, 2 pivot left, 3 pivot right.
REQ-010 cmd_counts  input  CNT_W  encoder edges to travel.
REQ-011 cmd_duty  input  PWM_W  PWM duty.
REQ-012 enc_a, enc_b  input  1 each  asynchronous quadrature encoder.
REQ-013 overide  input  1  asynchronous overcurrent flag, active-high.
REQ-014 in  output  4  H-bridge IN[4:1].
REQ-015 en_a, en_b  output  1 each  H-bridge enables (PWM).
REQ-016 busy  output  1  high outside IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 fault  output  1  sticky overcurrent flag, cleared by next accepted command.

Function
REQ-019 enc_a, enc_b, overide SHALL each pass a 2-flop synchroniser; all logic uses synchronised copies (2-cycle input latency).
REQ-020 Quadrature decode SHALL be x4: every valid state change increments edge counter; illegal double transitions ignored.
REQ-021 Edge counter SHALL saturate at 2^CNT_W-1, never wrap.
REQ-022 PWM counter SHALL free-run over PWM_W bits; pwm = (pwm_cnt < duty_reg); duty 0 = always off.
REQ-023 FSM states IDLE, RUN, BRAKE, LOCKOUT.
REQ-024 IDLE: in=0000, en_a=en_b=0; on transfer latch mode/counts/duty, clear edge counter and fault; mode 0 or counts 0 -> done next cycle, stay IDLE; else -> RUN.
REQ-025 RUN: en_a=en_b=pwm; in = forward 1010, pivot left 0110, pivot right 1001.
REQ-026 RUN -> BRAKE on cycle edge counter reaches counts_reg; overrun edges ignored.
REQ-027 BRAKE: in=1111, en_a=en_b=1 for exactly BRAKE_CYC cycles, then done pulse and -> IDLE.
REQ-028 Any state except IDLE: synchronised overide high -> LOCKOUT next cycle, fault=1; overide takes priority over count-reached in same cycle.
REQ-029 LOCKOUT: in=0000, en=0 for OC_HOLD cycles after overide last seen low; then done pulse, -> IDLE; fault stays set.
REQ-030 overide high in IDLE SHALL set fault and hold cmd_ready low until released.
REQ-031 enable low in any state SHALL force IDLE next cycle, outputs off, no done pulse; enable low SHALL hold cmd_ready low.
REQ-032 cmd_valid without cmd_ready SHALL be ignored; no queuing.

Reset
REQ-033 rst SHALL asynchronously force IDLE, in=0000, en_a=en_b=0, cmd_ready=0 until first clk after release, busy=0, done=0, fault=0, all counters and synchronisers 0.

Structure
REQ-034 Shared package SHALL hold FSM state enum, mode encodings, and IN patterns (fwd, pivot L/R, brake, off).
REQ-035 Quadrature decoder SHALL be sub-module quad_decoder (synchronisers plus edge pulse output).

Verification
REQ-036 Forward, counts=8, duty=128: 8 encoder edges -> BRAKE 1000 cycles, in=1111, then single done, in=0000.
REQ-037 Pivot right, counts=4, overide asserted after 2 edges -> LOCKOUT in <=3 cycles, en=0, fault=1, done after OC_HOLD.
REQ-038 counts=0 or mode 0 -> done next cycle, busy never high, outputs stay off.
REQ-039 enable dropped mid-RUN -> IDLE next cycle, no done; new command accepted after enable returns.
REQ-040 CNT_W=4, counts=15, 20 edges -> brake on 15th edge, counter holds 15.
REQ-041 rst asserted mid-BRAKE -> outputs zero immediately without clk edge.
